// File: rtl/bus_router_pkg.sv
// Shared types and constants for the bus_router interconnect.
//   state_t    : router FSM states
//   REGION_W   : width of the region field of an address
//   REGION_LSB : bit position of the region field in an address
//   idx_width  : width of a port index for a given follower count (min 1)
package bus_router_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR_RESP
    } state_t;

    localparam int REGION_W   = 4;
    localparam int REGION_LSB = 28;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_region_decoder.sv
// Combinational region decoder.
//   region_i  : addr[31:28] of the leader request
//   hit_o     : one-hot hit vector, only the lowest-index matching port set
//   hit_any_o : some port matched
//   hit_idx_o : index of the winning port (0 when nothing matched)
module bus_region_decoder
    import bus_router_pkg::*;
#(
    parameter int                                NUM_FOLLOWERS = 2,
    parameter logic [NUM_FOLLOWERS*REGION_W-1:0] REGION_IDS    = {4'h2, 4'h1},
    parameter int                                IDX_W         = idx_width(NUM_FOLLOWERS)
) (
    input  logic [REGION_W-1:0]      region_i,
    output logic [NUM_FOLLOWERS-1:0] hit_o,
    output logic                     hit_any_o,
    output logic [IDX_W-1:0]         hit_idx_o
);

    always_comb begin
        hit_o     = '0;
        hit_any_o = 1'b0;
        hit_idx_o = '0;
        // Ascending scan; the first match locks out later ports.
        for (int unsigned i = 0; i < NUM_FOLLOWERS; i++) begin
            if (!hit_any_o && (region_i == REGION_IDS[i*REGION_W +: REGION_W])) begin
                hit_o[i]  = 1'b1;
                hit_any_o = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_router.sv
// Leader-to-N-follower bus router.
//   clk, reset (async, active-high)
//   l_*  : leader request in (addr, write data, byte enables, read/write pulses),
//          read return out (data, valid), l_busy while a read is outstanding
//   f_*  : per-follower request out (masked addr, broadcast data/be, per-port
//          read/write request), per-follower read return in
//   err_valid / err_addr : registered error pulse and unmasked failing address
module bus_router
    import bus_router_pkg::*;
#(
    parameter int                                NUM_FOLLOWERS  = 2,
    parameter logic [NUM_FOLLOWERS*REGION_W-1:0] REGION_IDS     = {4'h2, 4'h1},
    parameter logic [31:0]                       OFFSET_MASK    = 32'h0FFF_FFFF,
    parameter int                                TIMEOUT_CYCLES = 16,
    parameter logic [31:0]                       ERROR_WORD     = 32'hDEAD_BEEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 l_addr,
    input  logic [31:0]                 l_write_data,
    input  logic [3:0]                  l_byte_enable,
    input  logic                        l_read_req,
    input  logic                        l_write_req,
    output logic [31:0]                 l_read_data,
    output logic                        l_read_data_valid,
    output logic                        l_busy,
    output logic [NUM_FOLLOWERS*32-1:0] f_addr,
    output logic [NUM_FOLLOWERS*32-1:0] f_write_data,
    output logic [NUM_FOLLOWERS*4-1:0]  f_byte_enable,
    output logic [NUM_FOLLOWERS-1:0]    f_read_req,
    output logic [NUM_FOLLOWERS-1:0]    f_write_req,
    input  logic [NUM_FOLLOWERS*32-1:0] f_read_data,
    input  logic [NUM_FOLLOWERS-1:0]    f_read_data_valid,
    output logic                        err_valid,
    output logic [31:0]                 err_addr
);

    localparam int IDX_W = idx_width(NUM_FOLLOWERS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   pend_q, pend_d;
    logic [31:0]        paddr_q, paddr_d;
    logic               err_valid_q, err_valid_d;
    logic [31:0]        err_addr_q, err_addr_d;

    logic [NUM_FOLLOWERS-1:0] hit;
    logic                     hit_any;
    logic [IDX_W-1:0]         hit_idx;

    logic                     hit_rvalid, pend_rvalid;
    logic [31:0]              hit_rdata, pend_rdata;

    bus_region_decoder #(
        .NUM_FOLLOWERS (NUM_FOLLOWERS),
        .REGION_IDS    (REGION_IDS),
        .IDX_W         (IDX_W)
    ) u_decoder (
        .region_i  (l_addr[REGION_LSB +: REGION_W]),
        .hit_o     (hit),
        .hit_any_o (hit_any),
        .hit_idx_o (hit_idx)
    );

    assign f_addr        = {NUM_FOLLOWERS{l_addr & OFFSET_MASK}};
    assign f_write_data  = {NUM_FOLLOWERS{l_write_data}};
    assign f_byte_enable = {NUM_FOLLOWERS{l_byte_enable}};
    assign err_valid     = err_valid_q;
    assign err_addr      = err_addr_q;

    // Return muxes: the decoded port (same-cycle reply) and the pending port.
    always_comb begin
        hit_rvalid  = 1'b0;
        hit_rdata   = '0;
        pend_rvalid = 1'b0;
        pend_rdata  = '0;
        for (int unsigned i = 0; i < NUM_FOLLOWERS; i++) begin
            if (hit_idx == IDX_W'(i)) begin
                hit_rvalid = f_read_data_valid[i];
                hit_rdata  = f_read_data[i*32 +: 32];
            end
            if (pend_q == IDX_W'(i)) begin
                pend_rvalid = f_read_data_valid[i];
                pend_rdata  = f_read_data[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        pend_d            = pend_q;
        paddr_d           = paddr_q;
        err_valid_d       = 1'b0;
        err_addr_d        = err_addr_q;
        f_read_req        = '0;
        f_write_req       = '0;
        l_read_data       = '0;
        l_read_data_valid = 1'b0;
        l_busy            = 1'b0;
        case (state_q)
            IDLE: begin
                if (l_read_req) begin
                    if (hit_any) begin
                        f_read_req = hit;
                        if (l_write_req) begin
                            f_write_req = hit;
                        end
                        if (hit_rvalid) begin
                            l_read_data_valid = 1'b1;
                            l_read_data       = hit_rdata;
                        end else begin
                            pend_d  = hit_idx;
                            paddr_d = l_addr;
                            cnt_d   = '0;
                            state_d = WAIT;
                        end
                    end else begin
                        // Unmapped read (with or without a write) reports one error.
                        err_valid_d = 1'b1;
                        err_addr_d  = l_addr;
                        state_d     = ERR_RESP;
                    end
                end else if (l_write_req) begin
                    if (hit_any) begin
                        f_write_req = hit;
                    end else begin
                        err_valid_d = 1'b1;
                        err_addr_d  = l_addr;
                    end
                end
            end
            WAIT: begin
                l_busy = 1'b1;
                if (pend_rvalid) begin
                    l_read_data_valid = 1'b1;
                    l_read_data       = pend_rdata;
                    state_d           = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_valid_d = 1'b1;
                    err_addr_d  = paddr_q;
                    state_d     = ERR_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR_RESP: begin
                l_busy            = 1'b1;
                l_read_data_valid = 1'b1;
                l_read_data       = ERROR_WORD;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            paddr_q     <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            paddr_q     <= paddr_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_bus_router.sv
// Self-checking bench for bus_router: a 2-port default instance driven from a
// vector table plus hand sequences, and a 4-port instance with regions 1..4.
module tb_bus_router;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 2-follower instance
    logic [31:0] l_addr, l_write_data, l_read_data, err_addr;
    logic [3:0]  l_byte_enable;
    logic        l_read_req, l_write_req, l_read_data_valid, l_busy, err_valid;
    logic [63:0] f_addr, f_write_data, f_read_data;
    logic [7:0]  f_byte_enable;
    logic [1:0]  f_read_req, f_write_req, f_read_data_valid;

    // 4-follower instance
    logic [31:0]  l4_addr, l4_write_data, l4_read_data, err4_addr;
    logic [3:0]   l4_byte_enable;
    logic         l4_read_req, l4_write_req, l4_read_data_valid, l4_busy, err4_valid;
    logic [127:0] f4_addr, f4_write_data, f4_read_data;
    logic [15:0]  f4_byte_enable;
    logic [3:0]   f4_read_req, f4_write_req, f4_read_data_valid;

    bus_router dut (
        .clk(clk), .reset(reset),
        .l_addr(l_addr), .l_write_data(l_write_data), .l_byte_enable(l_byte_enable),
        .l_read_req(l_read_req), .l_write_req(l_write_req),
        .l_read_data(l_read_data), .l_read_data_valid(l_read_data_valid), .l_busy(l_busy),
        .f_addr(f_addr), .f_write_data(f_write_data), .f_byte_enable(f_byte_enable),
        .f_read_req(f_read_req), .f_write_req(f_write_req),
        .f_read_data(f_read_data), .f_read_data_valid(f_read_data_valid),
        .err_valid(err_valid), .err_addr(err_addr)
    );

    bus_router #(
        .NUM_FOLLOWERS (4),
        .REGION_IDS    (16'h4321)
    ) dut4 (
        .clk(clk), .reset(reset),
        .l_addr(l4_addr), .l_write_data(l4_write_data), .l_byte_enable(l4_byte_enable),
        .l_read_req(l4_read_req), .l_write_req(l4_write_req),
        .l_read_data(l4_read_data), .l_read_data_valid(l4_read_data_valid), .l_busy(l4_busy),
        .f_addr(f4_addr), .f_write_data(f4_write_data), .f_byte_enable(f4_byte_enable),
        .f_read_req(f4_read_req), .f_write_req(f4_write_req),
        .f_read_data(f4_read_data), .f_read_data_valid(f4_read_data_valid),
        .err_valid(err4_valid), .err_addr(err4_addr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        l_read_req = 1'b0; l_write_req = 1'b0;
        f_read_data_valid = '0; f_read_data = '0;
        l4_read_req = 1'b0; l4_write_req = 1'b0;
        f4_read_data_valid = '0; f4_read_data = '0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rd;
        logic        wr;
        logic [1:0]  fvalid;
        logic [31:0] fdata0;
        logic [31:0] fdata1;
        logic [31:0] exp_faddr;
        logic [1:0]  exp_rreq;
        logic [1:0]  exp_wreq;
        logic        exp_rv;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        //        addr          wdata         be       rd    wr    fvld   fdata0        fdata1        faddr         rreq   wreq   rv    rdata         err
        vecs[0] = '{32'h2000_0010, 32'h0000_1234, 4'b0011, 1'b0, 1'b1, 2'b00, 32'h0,         32'h0,         32'h0000_0010, 2'b00, 2'b10, 1'b0, 32'h0,         1'b0};
        vecs[1] = '{32'h1000_0020, 32'h0000_CAFE, 4'b1111, 1'b0, 1'b1, 2'b00, 32'h0,         32'h0,         32'h0000_0020, 2'b00, 2'b01, 1'b0, 32'h0,         1'b0};
        vecs[2] = '{32'h1000_0008, 32'h0,         4'b0000, 1'b1, 1'b0, 2'b01, 32'h1111_2222, 32'h0,         32'h0000_0008, 2'b01, 2'b00, 1'b1, 32'h1111_2222, 1'b0};
        vecs[3] = '{32'h2ABC_0000, 32'h0,         4'b0000, 1'b1, 1'b0, 2'b10, 32'h0000_9999, 32'h3333_4444, 32'h0ABC_0000, 2'b10, 2'b00, 1'b1, 32'h3333_4444, 1'b0};
        vecs[4] = '{32'h1000_0040, 32'h0000_0055, 4'b0101, 1'b1, 1'b1, 2'b01, 32'h0000_0005, 32'h0,         32'h0000_0040, 2'b01, 2'b01, 1'b1, 32'h0000_0005, 1'b0};
        vecs[5] = '{32'hF000_0004, 32'h0000_0077, 4'b1111, 1'b0, 1'b1, 2'b00, 32'h0,         32'h0,         32'h0000_0004, 2'b00, 2'b00, 1'b0, 32'h0,         1'b1};
        vecs[6] = '{32'h1FFF_FFFF, 32'h0,         4'b0000, 1'b0, 1'b0, 2'b01, 32'h0000_ABCD, 32'h0,         32'h0FFF_FFFF, 2'b00, 2'b00, 1'b0, 32'h0,         1'b0};
        vecs[7] = '{32'h2FFF_FFFC, 32'h8000_0000, 4'b1000, 1'b0, 1'b1, 2'b00, 32'h0,         32'h0,         32'h0FFF_FFFC, 2'b00, 2'b10, 1'b0, 32'h0,         1'b0};

        reset = 1'b1;
        l_addr = '0; l_write_data = '0; l_byte_enable = '0;
        l4_addr = '0; l4_write_data = '0; l4_byte_enable = '0;
        clear_in();
        #2;
        chk("rst_valid", 32'(l_read_data_valid), 32'h0);
        chk("rst_data", l_read_data, 32'h0);
        chk("rst_busy", 32'(l_busy), 32'h0);
        chk("rst_err_valid", 32'(err_valid), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_freq", {28'h0, f_read_req, f_write_req}, 32'h0);
        cyc(); cyc();
        reset = 1'b0;
        cyc();

        // Table: single-cycle transactions that leave the router in IDLE.
        for (int i = 0; i < 8; i++) begin
            l_addr = vecs[i].addr; l_write_data = vecs[i].wdata; l_byte_enable = vecs[i].be;
            l_read_req = vecs[i].rd; l_write_req = vecs[i].wr;
            f_read_data_valid = vecs[i].fvalid;
            f_read_data = {vecs[i].fdata1, vecs[i].fdata0};
            #1;
            chk($sformatf("v%0d_faddr0", i), f_addr[31:0], vecs[i].exp_faddr);
            chk($sformatf("v%0d_faddr1", i), f_addr[63:32], vecs[i].exp_faddr);
            chk($sformatf("v%0d_wdata1", i), f_write_data[63:32], vecs[i].wdata);
            chk($sformatf("v%0d_be1", i), 32'(f_byte_enable[7:4]), 32'(vecs[i].be));
            chk($sformatf("v%0d_rreq", i), 32'(f_read_req), 32'(vecs[i].exp_rreq));
            chk($sformatf("v%0d_wreq", i), 32'(f_write_req), 32'(vecs[i].exp_wreq));
            chk($sformatf("v%0d_rv", i), 32'(l_read_data_valid), 32'(vecs[i].exp_rv));
            chk($sformatf("v%0d_rdata", i), l_read_data, vecs[i].exp_rdata);
            cyc();
            clear_in();
            #1;
            chk($sformatf("v%0d_post_err", i), 32'(err_valid), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_post_rv", i), 32'(l_read_data_valid), 32'h0);
            chk($sformatf("v%0d_post_busy", i), 32'(l_busy), 32'h0);
            if (vecs[i].exp_err) chk($sformatf("v%0d_err_addr", i), err_addr, vecs[i].addr);
        end

        // Read with reply three cycles later.
        l_addr = 32'h1000_0004; l_read_req = 1'b1;
        #1;
        chk("t1_faddr0", f_addr[31:0], 32'h0000_0004);
        chk("t1_rreq", 32'(f_read_req), 32'h1);
        chk("t1_busy0", 32'(l_busy), 32'h0);
        cyc(); clear_in();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t1_wait_busy", 32'(l_busy), 32'h1);
            chk("t1_wait_rv", 32'(l_read_data_valid), 32'h0);
            cyc();
        end
        f_read_data_valid = 2'b01; f_read_data = {32'h0, 32'hA5A5_0001};
        #1;
        chk("t1_busy3", 32'(l_busy), 32'h1);
        chk("t1_rv", 32'(l_read_data_valid), 32'h1);
        chk("t1_rdata", l_read_data, 32'hA5A5_0001);
        cyc(); clear_in();
        #1;
        chk("t1_busy_end", 32'(l_busy), 32'h0);
        chk("t1_rv_end", 32'(l_read_data_valid), 32'h0);

        // Unmapped read together with a write: one error, one response.
        l_addr = 32'h7000_0000; l_read_req = 1'b1; l_write_req = 1'b1;
        #1;
        chk("t3_reqs", {28'h0, f_read_req, f_write_req}, 32'h0);
        cyc(); clear_in(); l_addr = 32'h0;
        #1;
        chk("t3_rv", 32'(l_read_data_valid), 32'h1);
        chk("t3_rdata", l_read_data, 32'hDEAD_BEEF);
        chk("t3_err", 32'(err_valid), 32'h1);
        chk("t3_err_addr", err_addr, 32'h7000_0000);
        chk("t3_busy", 32'(l_busy), 32'h1);
        cyc();
        #1;
        chk("t3_err_once", 32'(err_valid), 32'h0);
        chk("t3_rv_end", 32'(l_read_data_valid), 32'h0);
        chk("t3_err_addr_held", err_addr, 32'h7000_0000);

        // Silent follower: 16 wait cycles then error; a late reply is ignored.
        l_addr = 32'h1000_0000; l_read_req = 1'b1;
        cyc(); clear_in();
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("t4_wait_rv", 32'(l_read_data_valid), 32'h0);
            chk("t4_wait_busy", 32'(l_busy), 32'h1);
            cyc();
        end
        #1;
        chk("t4_rv", 32'(l_read_data_valid), 32'h1);
        chk("t4_rdata", l_read_data, 32'hDEAD_BEEF);
        chk("t4_err", 32'(err_valid), 32'h1);
        chk("t4_err_addr", err_addr, 32'h1000_0000);
        cyc();
        #1;
        chk("t4_idle_busy", 32'(l_busy), 32'h0);
        cyc();
        f_read_data_valid = 2'b01; f_read_data = {32'h0, 32'h0BAD_0BAD};
        #1;
        chk("t4_late_rv", 32'(l_read_data_valid), 32'h0);
        chk("t4_late_data", l_read_data, 32'h0);
        cyc(); clear_in();

        // Reply on the last wait cycle before timeout is accepted.
        l_addr = 32'h1000_0100; l_read_req = 1'b1;
        cyc(); clear_in();
        for (int k = 0; k < 15; k++) cyc();
        f_read_data_valid = 2'b01; f_read_data = {32'h0, 32'h1A57_0001};
        #1;
        chk("t4b_rv", 32'(l_read_data_valid), 32'h1);
        chk("t4b_rdata", l_read_data, 32'h1A57_0001);
        cyc(); clear_in();
        #1;
        chk("t4b_no_err", 32'(err_valid), 32'h0);

        // Requests during WAIT are dropped; other ports' replies are ignored.
        l_addr = 32'h1000_0000; l_read_req = 1'b1;
        cyc(); clear_in();
        l_addr = 32'h2000_0000; l_read_req = 1'b1; l_write_req = 1'b1;
        f_read_data_valid = 2'b10; f_read_data = {32'h0000_0055, 32'h0};
        #1;
        chk("t5_rreq", 32'(f_read_req), 32'h0);
        chk("t5_wreq", 32'(f_write_req), 32'h0);
        chk("t5_spurious_rv", 32'(l_read_data_valid), 32'h0);
        cyc(); clear_in();
        f_read_data_valid = 2'b01; f_read_data = {32'h0, 32'h0000_0077};
        #1;
        chk("t5_rv", 32'(l_read_data_valid), 32'h1);
        chk("t5_rdata", l_read_data, 32'h0000_0077);
        cyc(); clear_in();

        // Reset two cycles into WAIT discards the in-flight reply.
        l_addr = 32'h1000_0000; l_read_req = 1'b1;
        cyc(); clear_in();
        cyc();
        reset = 1'b1;
        f_read_data_valid = 2'b01; f_read_data = {32'h0, 32'h0000_00EE};
        #1;
        chk("t6_rv", 32'(l_read_data_valid), 32'h0);
        chk("t6_busy", 32'(l_busy), 32'h0);
        chk("t6_err_addr", err_addr, 32'h0);
        cyc();
        reset = 1'b0; clear_in();
        #1;
        chk("t6_idle_rv", 32'(l_read_data_valid), 32'h0);
        l_addr = 32'h2000_0004; l_read_req = 1'b1;
        #1;
        chk("t6_rreq", 32'(f_read_req), 32'h2);
        cyc(); clear_in();
        f_read_data_valid = 2'b10; f_read_data = {32'h0000_600D, 32'h0};
        #1;
        chk("t6_rv_after", 32'(l_read_data_valid), 32'h1);
        chk("t6_rdata_after", l_read_data, 32'h0000_600D);
        cyc(); clear_in();

        // Four-follower instance: writes to each region.
        for (int p = 0; p < 4; p++) begin
            l4_addr = (32'(p + 1) << 28) | (32'h100 + 32'(p));
            l4_write_req = 1'b1;
            #1;
            chk($sformatf("n4_wreq%0d", p), 32'(f4_write_req), 32'(1 << p));
            chk($sformatf("n4_faddr%0d", p), f4_addr[p*32 +: 32], 32'h100 + 32'(p));
            cyc(); clear_in();
        end
        l4_addr = 32'h4000_0000; l4_read_req = 1'b1;
        #1;
        chk("n4_rreq", 32'(f4_read_req), 32'h8);
        cyc(); clear_in();
        f4_read_data_valid = 4'b0100; f4_read_data[95:64] = 32'h2222_2222;
        #1;
        chk("n4_spurious_rv", 32'(l4_read_data_valid), 32'h0);
        cyc(); clear_in();
        f4_read_data_valid = 4'b1000; f4_read_data[127:96] = 32'h4444_0004;
        #1;
        chk("n4_rv", 32'(l4_read_data_valid), 32'h1);
        chk("n4_rdata", l4_read_data, 32'h4444_0004);
        cyc(); clear_in();
        l4_addr = 32'h5000_0000; l4_write_req = 1'b1;
        #1;
        chk("n4_unmapped_wreq", 32'(f4_write_req), 32'h0);
        cyc(); clear_in();
        #1;
        chk("n4_err", 32'(err4_valid), 32'h1);
        chk("n4_err_addr", err4_addr, 32'h5000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
